// File: rtl/hdr_flit_multi_packetizer.sv
// Turns one packet descriptor plus a stream of body payloads into header, header-extension and body flits.
// Define PACKETIZER_STATS_EN to build the packet/flit statistics counters.
module hdr_flit_multi_packetizer #(
  parameter int NOC_ID = 0,
  parameter int DATA_w = 44,
  parameter int LENw   = 8,
  localparam int FPAYw   = (NOC_ID == 1) ? 64 : 32,
  localparam int V       = (NOC_ID == 1) ? 4 : 2,
  localparam int EAw     = (NOC_ID == 1) ? 8 : 4,
  localparam int DAw     = (NOC_ID == 1) ? 8 : 4,
  localparam int DSTPw   = 3,
  localparam int Cw      = 2,
  localparam int WEIGHTw = 4,
  localparam int BEw     = (NOC_ID == 1) ? 4 : 3,
  localparam int Fw      = FPAYw + V + 2,
  localparam int DINw    = (DATA_w > 0) ? DATA_w : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               desc_valid,
  output logic               desc_ready,
  input  logic [EAw-1:0]     src_e_addr_in,
  input  logic [DAw-1:0]     dest_e_addr_in,
  input  logic [DSTPw-1:0]   destport_in,
  input  logic [Cw-1:0]      class_in,
  input  logic [WEIGHTw-1:0] weight_in,
  input  logic [V-1:0]       vc_num_in,
  input  logic [BEw-1:0]     be_in,
  input  logic [DINw-1:0]    data_in,
  input  logic [LENw-1:0]    body_len_in,
  input  logic               body_valid,
  output logic               body_ready,
  input  logic [FPAYw-1:0]   body_data,
  output logic [Fw-1:0]      flit_out,
  output logic               flit_out_valid,
  input  logic               flit_out_ready,
  output logic [31:0]        pck_cnt_o,
  output logic [31:0]        flit_cnt_o
);

  // state | meaning
  // IDLE  | waiting for a descriptor, desc_ready high
  // HDR   | presenting the header flit
  // EXT   | presenting header-extension flit ext_cnt
  // BODY  | forwarding body payloads until body_len have transferred

  localparam int SRC_LSB  = 0;
  localparam int DST_LSB  = SRC_LSB + EAw;
  localparam int DSTP_LSB = DST_LSB + DAw;
  localparam int CLS_LSB  = DSTP_LSB + DSTPw;
  localparam int W_LSB    = CLS_LSB + Cw;
  localparam int BE_LSB   = W_LSB + WEIGHTw;
  localparam int MSB_BE   = BE_LSB + BEw - 1;
  localparam int HDR_ROOM = FPAYw - (MSB_BE + 1);
  localparam int EXT_N    = (DATA_w <= HDR_ROOM) ? 0 : (DATA_w - HDR_ROOM + FPAYw - 1) / FPAYw;
  localparam int EXTCw    = (EXT_N > 1) ? $clog2(EXT_N) : 1;
  // Padded so every ext_cnt value selects inside the vector, even unreachable ones.
  localparam int DPADw    = HDR_ROOM + (2 ** EXTCw) * FPAYw;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_EXT  = 2'd2,
    ST_BODY = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [EXTCw-1:0]   ext_cnt_q, ext_cnt_d;
  logic [LENw-1:0]    body_cnt_q, body_cnt_d;

  logic [EAw-1:0]     src_q;
  logic [DAw-1:0]     dest_q;
  logic [DSTPw-1:0]   destport_q;
  logic [Cw-1:0]      class_q;
  logic [WEIGHTw-1:0] weight_q;
  logic [V-1:0]       vc_q;
  logic [BEw-1:0]     be_q;
  logic [DINw-1:0]    data_q;
  logic [LENw-1:0]    body_len_q;

  logic               desc_accept;
  logic [DPADw-1:0]   data_pad;
  logic [FPAYw-1:0]   hdr_pay;
  logic [FPAYw-1:0]   ext_pay;
  logic [FPAYw-1:0]   payload;
  logic               first_flit;
  logic               last_flit;
  logic               ext_last;
  logic               body_last;

  assign desc_accept = desc_valid && desc_ready;
  assign data_pad    = (DATA_w > 0) ? DPADw'(data_q) : '0;
  assign ext_pay     = data_pad[HDR_ROOM + int'(ext_cnt_q) * FPAYw +: FPAYw];
  assign ext_last    = (ext_cnt_q == EXTCw'(EXT_N - 1));
  assign body_last   = (body_cnt_q == body_len_q - LENw'(1));

  always_comb begin
    hdr_pay = '0;
    hdr_pay[SRC_LSB +: EAw]      = src_q;
    hdr_pay[DST_LSB +: DAw]      = dest_q;
    hdr_pay[DSTP_LSB +: DSTPw]   = destport_q;
    hdr_pay[CLS_LSB +: Cw]       = class_q;
    hdr_pay[W_LSB +: WEIGHTw]    = weight_q;
    hdr_pay[BE_LSB +: BEw]       = be_q;
    hdr_pay[FPAYw-1:MSB_BE+1]    = data_pad[HDR_ROOM-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q      <= '0;
      dest_q     <= '0;
      destport_q <= '0;
      class_q    <= '0;
      weight_q   <= '0;
      vc_q       <= '0;
      be_q       <= '0;
      data_q     <= '0;
      body_len_q <= '0;
    end else if (desc_accept) begin
      src_q      <= src_e_addr_in;
      dest_q     <= dest_e_addr_in;
      destport_q <= destport_in;
      class_q    <= class_in;
      weight_q   <= weight_in;
      vc_q       <= vc_num_in;
      be_q       <= be_in;
      data_q     <= data_in;
      body_len_q <= body_len_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ext_cnt_q  <= '0;
      body_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ext_cnt_q  <= ext_cnt_d;
      body_cnt_q <= body_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ext_cnt_d      = ext_cnt_q;
    body_cnt_d     = body_cnt_q;
    desc_ready     = 1'b0;
    body_ready     = 1'b0;
    flit_out_valid = 1'b0;
    payload        = '0;
    first_flit     = 1'b0;
    last_flit      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Held low during reset so nothing is accepted while the block is cleared.
        desc_ready = !reset;
        if (desc_valid && !reset) begin
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        flit_out_valid = 1'b1;
        payload        = hdr_pay;
        first_flit     = 1'b1;
        last_flit      = (EXT_N == 0) && (body_len_q == '0);
        if (flit_out_ready) begin
          ext_cnt_d  = '0;
          body_cnt_d = '0;
          if (EXT_N > 0) begin
            state_d = ST_EXT;
          end else if (body_len_q != '0) begin
            state_d = ST_BODY;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_EXT: begin
        flit_out_valid = 1'b1;
        payload        = ext_pay;
        last_flit      = ext_last && (body_len_q == '0);
        if (flit_out_ready) begin
          if (ext_last) begin
            ext_cnt_d = '0;
            state_d   = (body_len_q != '0) ? ST_BODY : ST_IDLE;
          end else begin
            ext_cnt_d = ext_cnt_q + EXTCw'(1);
          end
        end
      end
      ST_BODY: begin
        flit_out_valid = body_valid;
        body_ready     = flit_out_ready;
        payload        = body_data;
        last_flit      = body_last;
        if (body_valid && flit_out_ready) begin
          if (body_last) begin
            body_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            body_cnt_d = body_cnt_q + LENw'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign flit_out = (state_q == ST_IDLE) ? '0 : {first_flit, last_flit, vc_q, payload};

`ifdef PACKETIZER_STATS_EN
  logic        xfer;
  logic [31:0] pck_cnt_q, pck_cnt_d;
  logic [31:0] flit_cnt_q, flit_cnt_d;

  assign xfer = flit_out_valid && flit_out_ready;

  always_comb begin
    pck_cnt_d  = pck_cnt_q;
    flit_cnt_d = flit_cnt_q;
    if (xfer) begin
      flit_cnt_d = flit_cnt_q + 32'd1;
      if (last_flit) begin
        pck_cnt_d = pck_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pck_cnt_q  <= '0;
      flit_cnt_q <= '0;
    end else begin
      pck_cnt_q  <= pck_cnt_d;
      flit_cnt_q <= flit_cnt_d;
    end
  end

  assign pck_cnt_o  = pck_cnt_q;
  assign flit_cnt_o = flit_cnt_q;
`else
  assign pck_cnt_o  = '0;
  assign flit_cnt_o = '0;
`endif

endmodule
